// File: rtl/magnitude_pipe_if.sv
// magnitude_pipe_if: sample/result handshake bundle for magnitude_pipe
// master drives samples, thresh and out_ready; slave returns in_ready and pixel/edge results.
interface magnitude_pipe_if #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 4
);
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic signed [IN_W-1:0]  gx_i;
  logic signed [IN_W-1:0]  gy_i;
  logic                    mode_i;
  logic [OUT_W-1:0]        thresh_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [OUT_W-1:0]        pixel_o;
  logic                    edge_o;
  modport master (
    output in_valid_i, gx_i, gy_i, mode_i, thresh_i, out_ready_i,
    input  in_ready_o, out_valid_o, pixel_o, edge_o
  );
  modport slave (
    input  in_valid_i, gx_i, gy_i, mode_i, thresh_i, out_ready_i,
    output in_ready_o, out_valid_o, pixel_o, edge_o
  );
endinterface

// File: rtl/magnitude_pipe.sv
// magnitude_pipe: 3-stage gradient magnitude (abs/shift, combine, quantize) with edge flag
// clk: clock; n_rst: async active-high reset; bus: slave side of magnitude_pipe_if
// (gx/gy/mode in with valid/ready, thresh, pixel/edge out with valid/ready).
module magnitude_pipe #(
  parameter int IN_W    = 10,
  parameter int SHIFT   = 4,
  parameter int OUT_W   = 4,
  parameter int STEP_SQ = 3,
  parameter int STEP_L1 = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  magnitude_pipe_if.slave   bus
);
  localparam int MAG_W = IN_W - 1 - SHIFT;
  localparam int SUM_W = 2 * MAG_W + 1;
  localparam logic [SUM_W-1:0] PIX_MAX = SUM_W'((1 << OUT_W) - 1);
  localparam logic [SUM_W-1:0] DIV_SQ  = SUM_W'(STEP_SQ);
  localparam logic [SUM_W-1:0] DIV_L1  = SUM_W'(STEP_L1);
  logic             en;
  logic             v1_q, v2_q, v3_q, m1_q, m2_q;
  logic [MAG_W-1:0] a_q, b_q, a_d, b_d;
  logic [SUM_W-1:0] sum_q, sum_d, quo;
  logic [OUT_W-1:0] pixel_q, pixel_d;
  logic             edge_q, edge_d;
  // Only the most negative input can overflow MAG_W after the shift; clamp it.
  function automatic logic [MAG_W-1:0] mag(input logic signed [IN_W-1:0] g);
    logic [IN_W-1:0] s;
    s = (g[IN_W-1] ? IN_W'(-g) : IN_W'(g)) >> SHIFT;
    return |(s >> MAG_W) ? '1 : s[MAG_W-1:0];
  endfunction
  always_comb begin
    en      = !v3_q || bus.out_ready_i;
    a_d     = mag(bus.gx_i);
    b_d     = mag(bus.gy_i);
    sum_d   = m1_q ? SUM_W'(a_q) + SUM_W'(b_q)
                   : SUM_W'(a_q) * SUM_W'(a_q) + SUM_W'(b_q) * SUM_W'(b_q);
    quo     = sum_q / (m2_q ? DIV_L1 : DIV_SQ);
    pixel_d = quo > PIX_MAX ? '1 : quo[OUT_W-1:0];
    edge_d  = pixel_d >= bus.thresh_i;
  end
  assign bus.in_ready_o  = en;
  assign bus.out_valid_o = v3_q;
  assign bus.pixel_o     = pixel_q;
  assign bus.edge_o      = edge_q;
  // One shared enable stalls every stage together, so nothing is lost or reordered.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      m1_q    <= 1'b0;
      m2_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      pixel_q <= '0;
      edge_q  <= 1'b0;
    end else if (en) begin
      v1_q    <= bus.in_valid_i;
      a_q     <= a_d;
      b_q     <= b_d;
      m1_q    <= bus.mode_i;
      v2_q    <= v1_q;
      sum_q   <= sum_d;
      m2_q    <= m1_q;
      v3_q    <= v2_q;
      pixel_q <= pixel_d;
      edge_q  <= edge_d;
    end
  end
endmodule

// File: tb/tb_magnitude_pipe.sv
// tb_magnitude_pipe: randomized and directed self-checking bench for magnitude_pipe
module tb_magnitude_pipe;
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic [3:0] thr = '0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct { int pix; int edg; int t; } rec_t;
  rec_t exp_q[$];
  rec_t obs_q[$];
  typedef struct { logic [9:0] gx; logic [9:0] gy; bit md; logic [3:0] th; int pix; int edg; } vec_t;
  magnitude_pipe_if bus ();
  magnitude_pipe dut (.clk(clk), .n_rst(n_rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic int model_pix(input logic [9:0] gx, input logic [9:0] gy, input bit md);
    int x, y, a, b, s, q;
    x = int'($signed(gx));
    y = int'($signed(gy));
    a = (x < 0 ? -x : x) / 16;
    b = (y < 0 ? -y : y) / 16;
    if (a > 31) a = 31;
    if (b > 31) b = 31;
    s = md ? a + b : a * a + b * b;
    q = s / (md ? 1 : 3);
    return q > 15 ? 15 : q;
  endfunction
  task automatic step(input bit iv, input logic [9:0] gx, input logic [9:0] gy, input bit md,
                      input bit ordy, output bit acc);
    int p;
    @(negedge clk);
    bus.in_valid_i  = iv;
    bus.gx_i        = gx;
    bus.gy_i        = gy;
    bus.mode_i      = md;
    bus.out_ready_i = ordy;
    bus.thresh_i    = thr;
    #1;
    if (bus.out_valid_o && ordy) obs_q.push_back('{int'(bus.pixel_o), int'(bus.edge_o), cyc});
    acc = iv && bus.in_ready_o;
    if (acc) begin
      p = model_pix(gx, gy, md);
      exp_q.push_back('{p, int'(p >= int'(thr)), cyc});
    end
    cyc++;
  endtask
  task automatic drain(output bit ok);
    bit acc;
    for (int i = 0; i < 30 && obs_q.size() < exp_q.size(); i++) step(0, '0, '0, 0, 1, acc);
    ok = obs_q.size() == exp_q.size();
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp += 4;
    if (bus.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid_o); end
    if (bus.pixel_o !== 4'd0) begin n_bad++; $display("FAIL reset_pixel got %0d want 0", bus.pixel_o); end
    if (bus.edge_o !== 1'b0) begin n_bad++; $display("FAIL reset_edge got %b want 0", bus.edge_o); end
    if (bus.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready_o); end
    n_rst = 1'b0;
  endtask
  task automatic test_vectors();
    vec_t vt[11] = '{
      '{10'd48,  10'd0,   0, 4'd0,  3,  1},
      '{10'h3D0, 10'h3E0, 0, 4'd5,  4,  0},
      '{10'h3D0, 10'h3E0, 0, 4'd4,  4,  1},
      '{10'h200, 10'd0,   0, 4'd15, 15, 1},
      '{10'd96,  10'd64,  1, 4'd11, 10, 0},
      '{10'd160, 10'd80,  1, 4'd15, 15, 1},
      '{10'd96,  10'd48,  0, 4'd15, 15, 1},
      '{10'd15,  10'h3F1, 0, 4'd1,  0,  0},
      '{10'h3EF, 10'd31,  1, 4'd2,  2,  1},
      '{10'h200, 10'h200, 1, 4'd15, 15, 1},
      '{10'd160, 10'd96,  1, 4'd15, 15, 1}
    };
    bit acc, ok;
    foreach (vt[i]) begin
      thr = vt[i].th;
      step(1, vt[i].gx, vt[i].gy, vt[i].md, 1, acc);
      drain(ok);
    end
    n_cmp++;
    if (obs_q.size() != 11) begin n_bad++; $display("FAIL vec_count got %0d want 11", obs_q.size()); end
    for (int i = 0; i < 11 && i < obs_q.size(); i++) begin
      n_cmp += 3;
      if (obs_q[i].pix !== vt[i].pix || obs_q[i].edg !== vt[i].edg) begin
        n_bad++; $display("FAIL vec[%0d] pixel/edge got %0d/%0d want %0d/%0d", i, obs_q[i].pix, obs_q[i].edg, vt[i].pix, vt[i].edg);
      end
      if (i < exp_q.size() && exp_q[i].pix !== vt[i].pix) begin
        n_bad++; $display("FAIL vec_model[%0d] got %0d want %0d", i, exp_q[i].pix, vt[i].pix);
      end
      if (i < exp_q.size() && obs_q[i].t - exp_q[i].t !== 3) begin
        n_bad++; $display("FAIL vec_latency[%0d] got %0d want 3", i, obs_q[i].t - exp_q[i].t);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask
  task automatic test_back_to_back();
    bit acc, ok;
    thr = 4'($urandom_range(0, 15));
    for (int i = 0; i < 24; i++)
      step(1, 10'($urandom), 10'($urandom), i[0] ^ 1'($urandom_range(0, 1)), 1, acc);
    drain(ok);
    n_cmp++;
    if (!ok || obs_q.size() != 24) begin n_bad++; $display("FAIL b2b_count got %0d want 24", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp += 2;
      if (obs_q[i].pix !== exp_q[i].pix || obs_q[i].edg !== exp_q[i].edg) begin
        n_bad++; $display("FAIL b2b[%0d] pixel/edge got %0d/%0d want %0d/%0d", i, obs_q[i].pix, obs_q[i].edg, exp_q[i].pix, exp_q[i].edg);
      end
      if (obs_q[i].t - exp_q[i].t !== 3) begin
        n_bad++; $display("FAIL b2b_latency[%0d] got %0d want 3", i, obs_q[i].t - exp_q[i].t);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask
  task automatic test_stall();
    logic [9:0] gxs[5], gys[5];
    bit mds[5];
    bit acc, ordy, ok;
    int sent = 0, f = -1;
    logic [3:0] held = '0;
    thr = 4'd6;
    for (int i = 0; i < 5; i++) begin
      gxs[i] = 10'($urandom);
      gys[i] = 10'($urandom);
      mds[i] = 1'($urandom_range(0, 1));
    end
    for (int c = 0; c < 40 && (sent < 5 || obs_q.size() < 5); c++) begin
      ordy = !(f >= 0 && c > f && c <= f + 4);
      step(sent < 5, sent < 5 ? gxs[sent] : '0, sent < 5 ? gys[sent] : '0, sent < 5 ? mds[sent] : 1'b0, ordy, acc);
      if (acc) sent++;
      if (f < 0 && obs_q.size() == 1) f = c;
      if (!ordy) begin
        if (c == f + 1) held = bus.pixel_o;
        n_cmp += 2;
        if (bus.in_ready_o !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready c=%0d got %b want 0", c, bus.in_ready_o); end
        if (bus.pixel_o !== held || bus.out_valid_o !== 1'b1) begin
          n_bad++; $display("FAIL stall_hold c=%0d pixel got %0d want %0d valid %b", c, bus.pixel_o, held, bus.out_valid_o);
        end
      end
    end
    drain(ok);
    n_cmp++;
    if (!ok || obs_q.size() != 5) begin n_bad++; $display("FAIL stall_count got %0d want 5", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i].pix !== exp_q[i].pix || obs_q[i].edg !== exp_q[i].edg) begin
        n_bad++; $display("FAIL stall_order[%0d] pixel/edge got %0d/%0d want %0d/%0d", i, obs_q[i].pix, obs_q[i].edg, exp_q[i].pix, exp_q[i].edg);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask
  task automatic test_reset_midstream();
    bit acc, ok;
    thr = 4'd3;
    for (int i = 0; i < 3; i++) step(1, 10'd160, 10'd0, 1, 1, acc);
    step(0, '0, '0, 0, 0, acc);
    @(negedge clk);
    #2 n_rst = 1'b1;
    #1;
    n_cmp += 3;
    if (bus.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid got %b want 0", bus.out_valid_o); end
    if (bus.pixel_o !== 4'd0) begin n_bad++; $display("FAIL midrst_pixel got %0d want 0", bus.pixel_o); end
    if (bus.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready_o); end
    exp_q.delete();
    obs_q.delete();
    @(negedge clk);
    n_rst = 1'b0;
    step(1, 10'd48, 10'd48, 0, 1, acc);
    drain(ok);
    n_cmp++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_bad++; $display("FAIL midrst_count got %0d want 1", obs_q.size());
    end else begin
      n_cmp += 2;
      if (obs_q[0].pix !== 6) begin n_bad++; $display("FAIL midrst_pixel_after got %0d want 6", obs_q[0].pix); end
      if (obs_q[0].t - exp_q[0].t !== 3) begin
        n_bad++; $display("FAIL midrst_latency got %0d want 3", obs_q[0].t - exp_q[0].t);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask
  task automatic test_random();
    bit acc, ok;
    thr = 4'($urandom_range(0, 15));
    for (int i = 0; i < 120; i++)
      step($urandom_range(0, 3) != 0, 10'($urandom), 10'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, acc);
    drain(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i].pix !== exp_q[i].pix || obs_q[i].edg !== exp_q[i].edg) begin
        n_bad++; $display("FAIL rand[%0d] pixel/edge got %0d/%0d want %0d/%0d", i, obs_q[i].pix, obs_q[i].edg, exp_q[i].pix, exp_q[i].edg);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask
  initial begin
    bus.in_valid_i  = 1'b0;
    bus.gx_i        = '0;
    bus.gy_i        = '0;
    bus.mode_i      = 1'b0;
    bus.thresh_i    = '0;
    bus.out_ready_i = 1'b1;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
